if_id_queue: RTL and testbench

Instruction queue between the fetch unit and the decode stage. Each cycle it accepts one fetched instruction word with its PC under a valid/ready handshake, buffers up to DEPTH entries in order, and presents the oldest entry to decode. When the queue is empty it drives a canonical NOP toward decode. A flush discards all buffered entries for redirects such as taken branches, jalr and traps.

---
 rtl/if_id_queue.sv | 125 ++++++++++++
 tb/tb_if_id_queue.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/if_id_queue.sv
// ----------------------------------------------------------------------------
// if_id_queue
//
// In-order instruction queue between fetch and decode. Fetch pushes one
// {pc, inst} pair per cycle under a valid/ready handshake. Decode sees the
// oldest entry, or a canonical NOP when the queue is empty. A flush drops every
// buffered entry, for example on a redirect.
//
// Parameters
//   DEPTH     number of entries (power of two, >= 2)
//   NOP_INST  word presented on id_inst while the queue is empty
//
// Ports
//   clk       clock, all state changes on the rising edge
//   rst_n     synchronous active-low reset (pointers and count only)
//   if_valid  fetch offers if_inst/if_pc this cycle
//   if_inst   fetched instruction word
//   if_pc     PC of if_inst
//   if_ready  queue can accept (not full)
//   id_valid  head entry valid toward decode
//   id_inst   head instruction, NOP_INST when empty
//   id_pc     head PC, zero when empty
//   id_ready  decode consumes the head this cycle
//   flush     discard all entries
//   count     number of occupied entries
// ----------------------------------------------------------------------------
module if_id_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     if_valid,
    input  logic [31:0]              if_inst,
    input  logic [31:0]              if_pc,
    output logic                     if_ready,
    output logic                     id_valid,
    output logic [31:0]              id_inst,
    output logic [31:0]              id_pc,
    input  logic                     id_ready,
    input  logic                     flush,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    // Each entry is {pc, inst}. The storage is deliberately not reset.
    logic [63:0]   mem_q [DEPTH];

    logic [PW-1:0] wp_q, wp_d;
    logic [PW-1:0] rp_q, rp_d;
    logic [CW-1:0] count_q, count_d;

    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic          wr_en;
    logic [63:0]   head;

    always_comb begin
        full    = (count_q == FULL_CNT);
        empty   = (count_q == '0);
        push    = if_valid && !full;
        pop     = id_ready && !empty;

        wp_d    = wp_q;
        rp_d    = rp_q;
        count_d = count_q;
        wr_en   = 1'b0;

        if (flush) begin
            // A flush drops the queue. Any push or pop in the same cycle is
            // ignored, and nothing is written.
            wp_d    = '0;
            rp_d    = '0;
            count_d = '0;
        end else begin
            if (push) begin
                // The write is also suppressed during reset, so a word offered
                // while rst_n is low never reaches storage.
                wr_en = rst_n;
                wp_d  = wp_q + 1'b1;
            end
            if (pop) begin
                rp_d = rp_q + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wp_q    <= '0;
            rp_q    <= '0;
            count_q <= '0;
        end else begin
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wp_q] <= {if_pc, if_inst};
        end
    end

    // The outputs depend only on registered state. Nothing is bypassed from
    // fetch to decode.
    assign head     = mem_q[rp_q];
    assign if_ready = !full;
    assign id_valid = !empty;
    assign id_inst  = empty ? NOP_INST : head[31:0];
    assign id_pc    = empty ? 32'h0 : head[63:32];
    assign count    = count_q;

endmodule

// File: tb/tb_if_id_queue.sv
module tb_if_id_queue;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_valid;
    logic [31:0] if_inst;
    logic [31:0] if_pc;
    logic        if_ready;
    logic        id_valid;
    logic [31:0] id_inst;
    logic [31:0] id_pc;
    logic        id_ready;
    logic        flush;
    logic [2:0]  count;

    int checks = 0;
    int errors = 0;

    if_id_queue #(.DEPTH(4), .NOP_INST(32'h0000_0013)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .if_valid (if_valid),
        .if_inst  (if_inst),
        .if_pc    (if_pc),
        .if_ready (if_ready),
        .id_valid (id_valid),
        .id_inst  (id_inst),
        .id_pc    (id_pc),
        .id_ready (id_ready),
        .flush    (flush),
        .count    (count)
    );

    always #5 clk = ~clk;

    // Advance one clock. Outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; if_valid = 1'b1; if_pc = 32'h500; if_inst = 32'hDEAD_BEEF;
        id_ready = 1'b0; flush = 1'b0;
        step();
        step();
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count); end
        checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL reset_id_valid got=%b exp=0", id_valid); end
        checks++; if (id_inst !== NOP) begin errors++; $display("FAIL reset_id_inst got=%h exp=%h", id_inst, NOP); end
        checks++; if (id_pc !== 32'h0) begin errors++; $display("FAIL reset_id_pc got=%h exp=0", id_pc); end
        checks++; if (if_ready !== 1'b1) begin errors++; $display("FAIL reset_if_ready got=%b exp=1", if_ready); end
        if_valid = 1'b0;
        rst_n = 1'b1;
        step();
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_no_accept got=%0d exp=0", count); end
    endtask

    task automatic test_single();
        if_valid = 1'b1; if_pc = 32'h100; if_inst = 32'h0000_006F; id_ready = 1'b0;
        step();
        if_valid = 1'b0;
        checks++; if (id_valid !== 1'b1) begin errors++; $display("FAIL single_valid got=%b exp=1", id_valid); end
        checks++; if (id_pc !== 32'h100) begin errors++; $display("FAIL single_pc got=%h exp=100", id_pc); end
        checks++; if (id_inst !== 32'h0000_006F) begin errors++; $display("FAIL single_inst got=%h exp=6f", id_inst); end
        checks++; if (count !== 3'd1) begin errors++; $display("FAIL single_count got=%0d exp=1", count); end
        id_ready = 1'b1;
        step();
        id_ready = 1'b0;
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL single_pop_count got=%0d exp=0", count); end
        checks++; if (id_inst !== NOP) begin errors++; $display("FAIL single_pop_nop got=%h exp=%h", id_inst, NOP); end
        checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL single_pop_valid got=%b exp=0", id_valid); end
    endtask

    task automatic test_fill();
        id_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if_valid = 1'b1; if_pc = 32'(i * 4); if_inst = 32'hA000_0000 + 32'(i);
            step();
        end
        checks++; if (count !== 3'd4) begin errors++; $display("FAIL fill_count got=%0d exp=4", count); end
        checks++; if (if_ready !== 1'b0) begin errors++; $display("FAIL fill_if_ready got=%b exp=0", if_ready); end
        // A fifth word offered while full must be ignored.
        if_valid = 1'b1; if_pc = 32'h10; if_inst = 32'hBAD0_0010;
        step();
        if_valid = 1'b0;
        checks++; if (count !== 3'd4) begin errors++; $display("FAIL full_ignore_count got=%0d exp=4", count); end
        checks++; if (id_pc !== 32'h0) begin errors++; $display("FAIL full_head_pc got=%h exp=0", id_pc); end
        id_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (id_valid !== 1'b1 || id_pc !== 32'(i * 4) || id_inst !== 32'hA000_0000 + 32'(i)) begin
                errors++;
                $display("FAIL drain_%0d got=v%b pc=%h inst=%h exp=v1 pc=%h inst=%h",
                         i, id_valid, id_pc, id_inst, 32'(i * 4), 32'hA000_0000 + 32'(i));
            end
            step();
        end
        id_ready = 1'b0;
        checks++; if (id_valid !== 1'b0 || count !== 3'd0) begin errors++; $display("FAIL drain_empty got=v%b cnt=%0d exp=v0 cnt=0", id_valid, count); end
    endtask

    task automatic test_stream();
        id_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if_valid = 1'b1; if_pc = 32'(i * 4); if_inst = 32'h0010_0000 + 32'(i);
            step();
            checks++;
            if (id_valid !== 1'b1 || id_pc !== 32'(i * 4) || id_inst !== 32'h0010_0000 + 32'(i) || count !== 3'd1) begin
                errors++;
                $display("FAIL stream_%0d got=v%b pc=%h inst=%h cnt=%0d exp=v1 pc=%h inst=%h cnt=1",
                         i, id_valid, id_pc, id_inst, count, 32'(i * 4), 32'h0010_0000 + 32'(i));
            end
        end
        if_valid = 1'b0;
        step();
        id_ready = 1'b0;
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL stream_end_count got=%0d exp=0", count); end
    endtask

    task automatic test_flush();
        id_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if_valid = 1'b1; if_pc = 32'h20 + 32'(i * 4); if_inst = 32'h0000_1000 + 32'(i);
            step();
        end
        checks++; if (count !== 3'd3) begin errors++; $display("FAIL flush_pre_count got=%0d exp=3", count); end
        flush = 1'b1; if_valid = 1'b1; if_pc = 32'h80; if_inst = 32'h0000_0080;
        step();
        flush = 1'b0; if_valid = 1'b0;
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL flush_count got=%0d exp=0", count); end
        checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got=%b exp=0", id_valid); end
        if_valid = 1'b1; if_pc = 32'h200; if_inst = 32'h0000_0200;
        step();
        if_valid = 1'b0;
        checks++; if (id_pc !== 32'h200 || count !== 3'd1) begin errors++; $display("FAIL flush_post_head got=pc%h cnt=%0d exp=pc200 cnt=1", id_pc, count); end
        id_ready = 1'b1;
        step();
        id_ready = 1'b0;
    endtask

    task automatic test_reset_midstream();
        id_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            if_valid = 1'b1; if_pc = 32'h300 + 32'(i * 4); if_inst = 32'h0000_3000 + 32'(i);
            step();
        end
        if_valid = 1'b0;
        checks++; if (count !== 3'd2) begin errors++; $display("FAIL midreset_pre got=%0d exp=2", count); end
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        checks++; if (count !== 3'd0 || id_valid !== 1'b0 || id_inst !== NOP) begin errors++; $display("FAIL midreset got=cnt%0d v%b inst=%h exp=cnt0 v0 inst=%h", count, id_valid, id_inst, NOP); end
    endtask

    task automatic test_random();
        logic [63:0] q[$];
        logic        do_push;
        logic        do_pop;
        logic [63:0] head;
        q.delete();
        for (int cyc = 0; cyc < 1000; cyc++) begin
            head = (q.size() != 0) ? q[0] : {32'h0, NOP};
            checks++;
            if (id_valid !== (q.size() != 0) || id_pc !== head[63:32] || id_inst !== head[31:0]
                || count !== 3'(q.size()) || if_ready !== (q.size() < 4)) begin
                errors++;
                $display("FAIL random_c%0d got=v%b pc=%h inst=%h cnt=%0d rdy=%b exp=v%b pc=%h inst=%h cnt=%0d rdy=%b",
                         cyc, id_valid, id_pc, id_inst, count, if_ready,
                         q.size() != 0, head[63:32], head[31:0], q.size(), q.size() < 4);
            end
            if_valid = 1'($urandom_range(0, 1));
            id_ready = 1'($urandom_range(0, 1));
            if_pc    = $urandom;
            if_inst  = $urandom;
            do_push  = if_valid && (q.size() < 4);
            do_pop   = id_ready && (q.size() > 0);
            step();
            if (do_pop)  void'(q.pop_front());
            if (do_push) q.push_back({if_pc, if_inst});
        end
        if_valid = 1'b0;
        id_ready = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; if_valid = 1'b0; if_inst = '0; if_pc = '0; id_ready = 1'b0; flush = 1'b0;
        test_reset();
        test_single();
        test_fill();
        test_stream();
        test_flush();
        test_reset_midstream();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
